// File: rtl/vga_pkg.sv
// Shared VGA constants and colour types for the pixel-source stages.
// The palette order sets the colour sequence the bouncing box steps through.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [23:0] rgb_t;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    localparam rgb_t PALETTE [8] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
        24'hFF00FF, 24'h00FFFF, 24'hFFFFFF, 24'hFF8000
    };

    function automatic rgb_t paletteLookup(input logic [2:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_bounce_box_gen_if.sv
// Pixel-source bus between the vga timing driver (master) and the box generator (slave).
interface vga_bounce_box_gen_if;

    logic [9:0] x_val;
    logic [9:0] y_val;
    logic       vsync;
    logic       pause;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       frame_tick;
    logic [7:0] bounce_count;

    modport master (
        output x_val, y_val, vsync, pause,
        input  red, green, blue, frame_tick, bounce_count
    );

    modport slave (
        input  x_val, y_val, vsync, pause,
        output red, green, blue, frame_tick, bounce_count
    );

endinterface

// File: rtl/bounce_axis.sv
// One axis of box motion: position, direction and a same-cycle hit flag.
// Positions are 11 bits so pos + SIZE + SPEED never wraps in the compare.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = 640,
    parameter int SIZE  = 32,
    parameter int SPEED = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_step,
    output logic [9:0] o_pos,
    output logic       o_hit
);

    localparam logic [10:0] L_LIMIT = 11'(LIMIT);
    localparam logic [10:0] L_SIZE  = 11'(SIZE);
    localparam logic [10:0] L_SPEED = 11'(SPEED);
    localparam logic [10:0] L_MAX   = 11'(LIMIT - SIZE);

    logic [10:0] r_pos;
    dir_e        r_dir;
    logic [10:0] w_next_pos;
    dir_e        w_next_dir;
    logic        w_hit;

    // A hit clamps the box flush against the edge and reverses direction.
    always_comb begin
        w_next_pos = r_pos;
        w_next_dir = r_dir;
        w_hit      = 1'b0;
        if (i_step) begin
            if (r_dir == DIR_FWD) begin
                if (r_pos + L_SIZE + L_SPEED > L_LIMIT) begin
                    w_next_pos = L_MAX;
                    w_next_dir = DIR_REV;
                    w_hit      = 1'b1;
                end else begin
                    w_next_pos = r_pos + L_SPEED;
                end
            end else begin
                if (r_pos < L_SPEED) begin
                    w_next_pos = '0;
                    w_next_dir = DIR_FWD;
                    w_hit      = 1'b1;
                end else begin
                    w_next_pos = r_pos - L_SPEED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= '0;
            r_dir <= DIR_FWD;
        end else begin
            r_pos <= w_next_pos;
            r_dir <= w_next_dir;
        end
    end

    assign o_pos = r_pos[9:0];
    assign o_hit = w_hit;

endmodule

// File: rtl/vga_bounce_box_gen.sv
// Pixel source: a palette-coloured box bouncing once per frame over a gradient.
// RGB is registered one cycle behind x_val/y_val; the vga driver delays sync to match.
module vga_bounce_box_gen #(
    parameter int   H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int   V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int   BOX_SIZE  = 32,
    parameter int   SPEED     = 2,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic                 board_clock,
    input  logic                 rst_n,
    vga_bounce_box_gen_if.slave  bus
);

    import vga_pkg::*;

    logic       r_vsync_d;
    logic       r_frame_tick;
    logic [2:0] r_pal_idx;
    logic [7:0] r_bounce_count;
    rgb_t       r_rgb;

    logic       w_vsync_rise;
    logic       w_step;
    logic       w_hit_x;
    logic       w_hit_y;
    logic [9:0] w_box_x;
    logic [9:0] w_box_y;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic       w_active;
    logic       w_inside;
    rgb_t       w_rgb;

    assign w_vsync_rise = (bus.vsync == VSYNC_POL) && (r_vsync_d != VSYNC_POL);
    assign w_step       = r_frame_tick && !bus.pause;

    bounce_axis #(.LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .SPEED(SPEED)) u_axis_x (
        .clk    (board_clock),
        .rst_n  (rst_n),
        .i_step (w_step),
        .o_pos  (w_box_x),
        .o_hit  (w_hit_x)
    );

    bounce_axis #(.LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .SPEED(SPEED)) u_axis_y (
        .clk    (board_clock),
        .rst_n  (rst_n),
        .i_step (w_step),
        .o_pos  (w_box_y),
        .o_hit  (w_hit_y)
    );

    // A corner hit on both axes still counts as a single bounce.
    always_ff @(posedge board_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d      <= ~VSYNC_POL;
            r_frame_tick   <= 1'b0;
            r_pal_idx      <= '0;
            r_bounce_count <= '0;
        end else begin
            r_vsync_d    <= bus.vsync;
            r_frame_tick <= w_vsync_rise;
            if (w_hit_x || w_hit_y) begin
                r_pal_idx      <= r_pal_idx + 3'd1;
                r_bounce_count <= r_bounce_count + 8'd1;
            end
        end
    end

    assign w_x      = {1'b0, bus.x_val};
    assign w_y      = {1'b0, bus.y_val};
    assign w_active = (w_x < 11'(H_ACTIVE)) && (w_y < 11'(V_ACTIVE));
    assign w_inside = w_active
                   && ({1'b0, w_box_x} <= w_x) && (w_x < {1'b0, w_box_x} + 11'(BOX_SIZE))
                   && ({1'b0, w_box_y} <= w_y) && (w_y < {1'b0, w_box_y} + 11'(BOX_SIZE));

    always_comb begin
        w_rgb = '0;
        if (w_inside) begin
            w_rgb = paletteLookup(r_pal_idx);
        end else if (w_active) begin
            w_rgb = {8'h00, bus.y_val[8:1], bus.x_val[9:2]};
        end
    end

    always_ff @(posedge board_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign bus.red          = r_rgb[23:16];
    assign bus.green        = r_rgb[15:8];
    assign bus.blue         = r_rgb[7:0];
    assign bus.frame_tick   = r_frame_tick;
    assign bus.bounce_count = r_bounce_count;

endmodule

// File: tb/tb_vga_bounce_box_gen.sv
// Self-checking bench for vga_bounce_box_gen: fixed vectors, frame sequences and
// random pixel probes compared against a frame-level model of the bouncing box.
module tb_vga_bounce_box_gen;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vga_bounce_box_gen_if busA ();
    vga_bounce_box_gen_if busB ();

    vga_bounce_box_gen #(
        .H_ACTIVE(640), .V_ACTIVE(480), .BOX_SIZE(32), .SPEED(2), .VSYNC_POL(1'b0)
    ) dutA (
        .board_clock (clk),
        .rst_n       (rst_n),
        .bus         (busA.slave)
    );

    vga_bounce_box_gen #(
        .H_ACTIVE(96), .V_ACTIVE(96), .BOX_SIZE(32), .SPEED(2), .VSYNC_POL(1'b0)
    ) dutB (
        .board_clock (clk),
        .rst_n       (rst_n),
        .bus         (busB.slave)
    );

    typedef struct {
        int pos;
        bit rev;
    } axisModel_t;

    typedef struct {
        axisModel_t ax;
        axisModel_t ay;
        int pal;
        int bounces;
        int h;
        int v;
        int box;
        int speed;
    } boxModel_t;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } vector_t;

    logic [23:0] palette [8] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
        24'hFF00FF, 24'h00FFFF, 24'hFFFFFF, 24'hFF8000
    };

    int checks   = 0;
    int failures = 0;
    boxModel_t mA;
    boxModel_t mB;

    // The box travels SPEED per frame and lands flush on an edge when the next step would overrun it.
    function automatic axisModel_t moveAxis(input axisModel_t a, input int limit, input int size,
                                            input int speed, output bit hit);
        hit = 1'b0;
        if (!a.rev) begin
            if (a.pos + size + speed > limit) begin
                a.pos = limit - size;
                a.rev = 1'b1;
                hit   = 1'b1;
            end else begin
                a.pos = a.pos + speed;
            end
        end else begin
            if (a.pos < speed) begin
                a.pos = 0;
                a.rev = 1'b0;
                hit   = 1'b1;
            end else begin
                a.pos = a.pos - speed;
            end
        end
        return a;
    endfunction

    function automatic boxModel_t modelFrame(input boxModel_t m, input bit paused);
        bit hx;
        bit hy;
        if (paused) return m;
        m.ax = moveAxis(m.ax, m.h, m.box, m.speed, hx);
        m.ay = moveAxis(m.ay, m.v, m.box, m.speed, hy);
        if (hx || hy) begin
            m.pal     = (m.pal + 1) % 8;
            m.bounces = (m.bounces + 1) % 256;
        end
        return m;
    endfunction

    function automatic boxModel_t modelReset(input int h, input int v, input int box, input int speed);
        boxModel_t m;
        m.ax      = '{pos: 0, rev: 1'b0};
        m.ay      = '{pos: 0, rev: 1'b0};
        m.pal     = 0;
        m.bounces = 0;
        m.h       = h;
        m.v       = v;
        m.box     = box;
        m.speed   = speed;
        return m;
    endfunction

    function automatic logic [23:0] modelPixel(input boxModel_t m, input int x, input int y);
        if (x >= m.h || y >= m.v) return 24'h000000;
        if (x >= m.ax.pos && x < m.ax.pos + m.box && y >= m.ay.pos && y < m.ay.pos + m.box)
            return palette[m.pal];
        return {8'h00, 8'((y / 2) % 256), 8'((x / 4) % 256)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input int x, input int y);
        @(negedge clk);
        if (sel) begin
            busB.x_val = 10'(x);
            busB.y_val = 10'(y);
        end else begin
            busA.x_val = 10'(x);
            busA.y_val = 10'(y);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic probePixel(input bit sel, input string name, input int x, input int y);
        applyStimulus(sel, x, y);
        if (sel)
            checkOutput($sformatf("%s(%0d,%0d)", name, x, y), {8'h00, busB.red, busB.green, busB.blue},
                        {8'h00, modelPixel(mB, x, y)});
        else
            checkOutput($sformatf("%s(%0d,%0d)", name, x, y), {8'h00, busA.red, busA.green, busA.blue},
                        {8'h00, modelPixel(mA, x, y)});
    endtask

    task automatic probeBox(input string name);
        probePixel(0, {name, "_in"}, mA.ax.pos, mA.ay.pos);
        probePixel(0, {name, "_far"}, mA.ax.pos + 31, mA.ay.pos + 31);
        probePixel(0, {name, "_right"}, mA.ax.pos + 32, mA.ay.pos);
        if (mA.ax.pos > 0) probePixel(0, {name, "_left"}, mA.ax.pos - 1, mA.ay.pos);
    endtask

    task automatic randomProbes(input int n);
        int x;
        int y;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) begin
                x = $urandom_range(0, 700);
                y = $urandom_range(0, 520);
            end else begin
                x = mA.ax.pos + $urandom_range(0, 40);
                y = mA.ay.pos + $urandom_range(0, 40);
                x = (x >= 4) ? x - 4 : x;
                y = (y >= 4) ? y - 4 : y;
            end
            probePixel(0, "rand", x, y);
        end
    endtask

    // Each frame: vsync active for 4 cycles, inactive for 4; frame_tick high-cycles are counted.
    task automatic runFrames(input bit sel, input int n, input bit p);
        int ticks;
        ticks = 0;
        for (int f = 0; f < n; f++) begin
            @(negedge clk);
            if (sel) begin busB.pause = p; busB.vsync = 1'b0; end
            else     begin busA.pause = p; busA.vsync = 1'b0; end
            repeat (4) begin
                @(posedge clk); #1;
                if ((sel ? busB.frame_tick : busA.frame_tick) === 1'b1) ticks++;
            end
            @(negedge clk);
            if (sel) busB.vsync = 1'b1; else busA.vsync = 1'b1;
            repeat (4) begin
                @(posedge clk); #1;
                if ((sel ? busB.frame_tick : busA.frame_tick) === 1'b1) ticks++;
            end
            if (sel) mB = modelFrame(mB, p); else mA = modelFrame(mA, p);
        end
        checkOutput($sformatf("frameTicks%0d", n), 32'(ticks), 32'(n));
        if (sel) checkOutput("bounceCountB", {24'h0, busB.bounce_count}, 32'(mB.bounces));
        else     checkOutput("bounceCountA", {24'h0, busA.bounce_count}, 32'(mA.bounces));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t vectors [10];
        vectors[0] = '{x: 10'd5,    y: 10'd5,    rgb: 24'hFF0000};
        vectors[1] = '{x: 10'd40,   y: 10'd5,    rgb: 24'h00020A};
        vectors[2] = '{x: 10'd31,   y: 10'd31,   rgb: 24'hFF0000};
        vectors[3] = '{x: 10'd32,   y: 10'd0,    rgb: 24'h000008};
        vectors[4] = '{x: 10'd0,    y: 10'd32,   rgb: 24'h001000};
        vectors[5] = '{x: 10'd639,  y: 10'd479,  rgb: 24'h00EF9F};
        vectors[6] = '{x: 10'd640,  y: 10'd5,    rgb: 24'h000000};
        vectors[7] = '{x: 10'd5,    y: 10'd480,  rgb: 24'h000000};
        vectors[8] = '{x: 10'd1023, y: 10'd1023, rgb: 24'h000000};
        vectors[9] = '{x: 10'd0,    y: 10'd0,    rgb: 24'hFF0000};

        rst_n = 1'b0;
        busA.x_val = '0; busA.y_val = '0; busA.vsync = 1'b1; busA.pause = 1'b0;
        busB.x_val = '0; busB.y_val = '0; busB.vsync = 1'b1; busB.pause = 1'b0;
        mA = modelReset(640, 480, 32, 2);
        mB = modelReset(96, 96, 32, 2);
        #1;
        checkOutput("resetRgb", {8'h00, busA.red, busA.green, busA.blue}, 32'h0);
        checkOutput("resetTick", {31'h0, busA.frame_tick}, 32'h0);
        checkOutput("resetBounce", {24'h0, busA.bounce_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, vectors[i].x, vectors[i].y);
            checkOutput($sformatf("vector%0d", i), {8'h00, busA.red, busA.green, busA.blue},
                        {8'h00, vectors[i].rgb});
        end

        runFrames(0, 10, 1'b0);
        applyStimulus(0, 19, 19);
        checkOutput("bg19", {8'h00, busA.red, busA.green, busA.blue}, 32'h000904);
        applyStimulus(0, 20, 20);
        checkOutput("box20", {8'h00, busA.red, busA.green, busA.blue}, 32'hFF0000);
        applyStimulus(0, 52, 20);
        checkOutput("bg52", {8'h00, busA.red, busA.green, busA.blue}, 32'h000A0D);
        randomProbes(10);

        runFrames(0, 294, 1'b0);
        probeBox("f304");
        runFrames(0, 1, 1'b0);
        checkOutput("bounceAt305", {24'h0, busA.bounce_count}, 32'd2);
        applyStimulus(0, 608, 288);
        checkOutput("box305", {8'h00, busA.red, busA.green, busA.blue}, 32'h0000FF);
        applyStimulus(0, 607, 288);
        checkOutput("bg305", {8'h00, busA.red, busA.green, busA.blue}, 32'h009097);
        runFrames(0, 1, 1'b0);
        applyStimulus(0, 606, 286);
        checkOutput("box306", {8'h00, busA.red, busA.green, busA.blue}, 32'h0000FF);
        probeBox("f306");
        randomProbes(20);

        runFrames(0, 5, 1'b1);
        probeBox("paused");
        @(negedge clk); busA.pause = 1'b1;
        @(negedge clk); busA.pause = 1'b0;
        runFrames(0, 1, 1'b0);
        probeBox("resumed");
        runFrames(0, 3, 1'b0);
        probeBox("moving");

        runFrames(1, 32, 1'b0);
        checkOutput("cornerBefore", {24'h0, busB.bounce_count}, 32'd0);
        runFrames(1, 1, 1'b0);
        checkOutput("cornerBounce", {24'h0, busB.bounce_count}, 32'd1);
        applyStimulus(1, 64, 64);
        checkOutput("cornerColour", {8'h00, busB.red, busB.green, busB.blue}, 32'h00FF00);
        probePixel(1, "cornerEdge", 63, 63);
        probePixel(1, "cornerOut", 96, 64);

        applyStimulus(0, 100, 100);
        checkOutput("preResetRgb", {8'h00, busA.red, busA.green, busA.blue}, {8'h00, modelPixel(mA, 100, 100)});
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRgb", {8'h00, busA.red, busA.green, busA.blue}, 32'h0);
        checkOutput("asyncBounce", {24'h0, busA.bounce_count}, 32'h0);
        checkOutput("asyncBounceB", {24'h0, busB.bounce_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mA = modelReset(640, 480, 32, 2);
        mB = modelReset(96, 96, 32, 2);
        applyStimulus(0, 5, 5);
        checkOutput("redrawOrigin", {8'h00, busA.red, busA.green, busA.blue}, 32'hFF0000);
        probeBox("afterReset");
        runFrames(0, 1, 1'b0);
        probeBox("afterResetMove");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
